regfile_dump_reader: RTL

Read-side companion to register_file. On a start pulse, it walks all architectural registers through one combinational register file read port (A1/RD1 or A2/RD2). It streams each value out over a valid/ready interface, tagged with its register index. Used for debug dumps, end-of-test register checks and state scan-out, without touching the decode-stage read path.

---
 rtl/regfile_dump_reader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// Walks every architectural register through one combinational register file
// read port and streams the values out over a valid/ready interface.
module regfile_dump_reader #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_last
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      SEND
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_t              state_q,     state_d;
   logic [ADDR_W-1:0]   rd_ptr_q,    rd_ptr_d;
   logic                busy_q,      busy_d;
   logic                done_q,      done_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q,  out_data_d;
   logic [ADDR_W-1:0]   out_index_q, out_index_d;
   logic                out_last_q,  out_last_d;
   logic                capture;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      out_last_d  = out_last_q;
      capture     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               rd_ptr_d = '0;
               busy_d   = 1'b1;
               state_d  = READ;
            end
         end
         READ: begin
            capture = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            if (out_ready) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
                  rd_ptr_d    = '0;
                  state_d     = IDLE;
               end else begin
                  // Accepting a beat refills the output stage on the same edge.
                  capture = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (capture) begin
         out_data_d  = rf_data;
         out_index_d = rd_ptr_q;
         out_last_d  = (rd_ptr_q == LAST_IDX);
         rd_ptr_d    = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + ADDR_W'(1);
         out_valid_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         rd_ptr_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         out_last_q  <= out_last_d;
      end
   end

   assign rf_addr   = rd_ptr_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_index = out_index_q;
   assign out_last  = out_last_q;

endmodule
